// File: rtl/y_arith_pkg.sv
// Shared encodings and helpers for the sequential add/subtract datapath:
// FSM states, operation mode, and the single-bit full-adder cell.
package y_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Full-adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    full_add = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

endpackage

// File: rtl/y_adder_chunk.sv
// CHUNK-bit ripple-carry adder built from full-adder cells; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module y_adder_chunk
  import y_arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_top
);

  logic [W:0] c;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
    end
  end

  assign cout  = c[W];
  assign c_top = c[W-1];

endmodule

// File: rtl/y_seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-wide adder is reused across
// WIDTH/CHUNK cycles, rippling the carry through a register between chunks.
module y_seq_adder
  import y_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] z_q,     z_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
  logic             chunk_cout, chunk_ctop;
  mode_e            mode;

  assign mode    = mode_e'(sub);
  assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

  y_adder_chunk #(.W(CHUNK)) u_chunk (
    .a     (chunk_a),
    .b     (chunk_b),
    .cin   (carry_q),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_top (chunk_ctop)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
          a_d     = a;
          b_d     = (mode == MODE_SUB) ? ~b : b;
          carry_d = (mode == MODE_SUB);
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        z_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
        carry_d = chunk_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_cout;
          ovf_d   = chunk_cout ^ chunk_ctop;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign z    = z_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_y_seq_adder.sv
// Self-checking bench for y_seq_adder: directed table, corner sequences,
// random operations and an exhaustive 4-bit/1-bit-chunk sweep.
module tb_y_seq_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_r;
  logic       sub_r;
  logic [7:0] a_r, b_r;

  logic [2:0] busy_v, done_v, cout_v, ovf_v;
  logic [7:0] z_v [3];
  logic [3:0] z4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // d0: WIDTH=8 CHUNK=4 (N=2); d1: WIDTH=4 CHUNK=1 (N=4); d2: WIDTH=8 CHUNK=8 (N=1)
  y_seq_adder #(.WIDTH(8), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .sub(sub_r), .a(a_r), .b(b_r),
    .busy(busy_v[0]), .done(done_v[0]), .z(z_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

  y_seq_adder #(.WIDTH(4), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .sub(sub_r), .a(a_r[3:0]), .b(b_r[3:0]),
    .busy(busy_v[1]), .done(done_v[1]), .z(z4), .cout(cout_v[1]), .ovf(ovf_v[1]));

  assign z_v[1] = {4'b0, z4};

  y_seq_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .sub(sub_r), .a(a_r), .b(b_r),
    .busy(busy_v[2]), .done(done_v[2]), .z(z_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on a w-bit word; returns {ovf, cout, z[7:0]}.
  function automatic logic [9:0] model(input int w, input int ai, input int bi, input logic s);
    longint modv = longint'(1) << w;
    longint half = modv / 2;
    longint raw  = s ? (longint'(ai) + (modv - 1 - bi) + 1) : (longint'(ai) + bi);
    longint sa   = (ai >= half) ? ai - modv : ai;
    longint sb   = (bi >= half) ? bi - modv : bi;
    longint r    = s ? sa - sb : sa + sb;
    logic   o    = (r < -half) || (r >= half);
    model = {o, logic'(raw >= modv), 8'(raw % modv)};
  endfunction

  function automatic int width_of(input int d);
    return (d == 1) ? 4 : 8;
  endfunction

  function automatic int chunks_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 4 : 1;
  endfunction

  // Entered and left on a falling edge. Inputs are scrambled after acceptance.
  task automatic do_op(input int d, input logic [7:0] ai, input logic [7:0] bi, input logic si);
    int         w    = width_of(d);
    int         mask = (1 << w) - 1;
    logic [9:0] exp  = model(w, int'(ai) & mask, int'(bi) & mask, si);
    logic [7:0] zr;
    int         e    = 0;
    a_r = ai; b_r = bi; sub_r = si; start_r[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r[d] = 1'b0;
    a_r = 8'($urandom); b_r = 8'($urandom); sub_r = 1'($urandom);
    while (!done_v[d] && e < 20) begin
      check("busy_during_run", busy_v[d], 1);
      @(negedge clk);
      e++;
    end
    check("latency", e, chunks_of(d));
    check("busy_at_done", busy_v[d], 0);
    check("z", z_v[d], exp[7:0]);
    check("cout", cout_v[d], exp[8]);
    check("ovf", ovf_v[d], exp[9]);
    zr = z_v[d];
    @(negedge clk);
    check("done_one_cycle", done_v[d], 0);
    check("busy_after_done", busy_v[d], 0);
    check("z_hold", z_v[d], zr);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] z;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] zr;
    int         f0;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0; start_r = '0; sub_r = 1'b0; a_r = '0; b_r = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      check("reset_busy", busy_v[d], 0);
      check("reset_done", done_v[d], 0);
      check("reset_z", z_v[d], 0);
      check("reset_cout", cout_v[d], 0);
      check("reset_ovf", ovf_v[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table against hand-derived results, on both 8-bit variants.
    for (int i = 0; i < 7; i++) begin
      for (int d = 0; d < 3; d += 2) begin
        do_op(d, vecs[i].a, vecs[i].b, vecs[i].sub);
        check("tbl_z", z_v[d], vecs[i].z);
        check("tbl_cout", cout_v[d], vecs[i].cout);
        check("tbl_ovf", ovf_v[d], vecs[i].ovf);
      end
    end

    // Idle holds the result while start stays low.
    zr = z_v[0];
    repeat (3) @(negedge clk);
    check("idle_hold_z", z_v[0], zr);
    check("idle_busy", busy_v[0], 0);

    // Start re-pulsed during RUN and during DONE is ignored.
    a_r = 8'h0F; b_r = 8'h01; sub_r = 1'b0; start_r[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    a_r = 8'h7F; b_r = 8'h7F; sub_r = 1'b1;
    @(posedge clk); @(negedge clk);
    check("repulse_busy", busy_v[0], 1);
    @(posedge clk); @(negedge clk);
    check("repulse_done", done_v[0], 1);
    check("repulse_z", z_v[0], 8'h10);
    check("repulse_cout", cout_v[0], 0);
    @(posedge clk); @(negedge clk);
    start_r[0] = 1'b0;
    check("start_in_done_ignored", busy_v[0], 0);
    check("repulse_z_hold", z_v[0], 8'h10);
    @(negedge clk);

    // Reset mid-operation: outputs clear at once, no done follows.
    a_r = 8'h33; b_r = 8'h44; sub_r = 1'b0; start_r[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    start_r[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy_v[0], 0);
    check("abort_z", z_v[0], 0);
    check("abort_cout", cout_v[0], 0);
    check("abort_ovf", ovf_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    f0 = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) f0++;
    end
    check("abort_no_done", f0, 0);
    do_op(0, 8'h12, 8'h34, 1'b0);
    check("post_reset_z", z_v[0], 8'h46);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      do_op((i % 2 == 0) ? 0 : 2, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Exhaustive 4-bit sweep with one-bit chunks.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          f0 = failures;
          do_op(1, 8'(x), 8'(y), 1'(s));
          if (failures == f0) $display("PASS vec a=%0h b=%0h sub=%0d", x, y, s);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y_seq_adder.md
Y_SEQ_ADDER -- requirements
Module: y_seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  first operand; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  second operand; sampled with start.
REQ-009 SHALL have port busy  output  1  high while chunks are being processed.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results are valid.
REQ-011 SHALL have port z  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out of MSB; for sub, 1 means no borrow.
REQ-013 SHALL have port ovf  output  1  signed two's-complement overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/CHUNK.
REQ-015 IDLE: start=1 at an edge SHALL latch a, b XOR {WIDTH{sub}}, carry=sub, chunk index=0, and move to RUN.
REQ-016 IDLE: start=0 SHALL keep IDLE, and z/cout/ovf SHALL hold their values.
REQ-017 RUN: each edge SHALL add chunk[index] of the latched operands plus the carry register, write it to z chunk[index], update carry, and increment index.
REQ-018 RUN: the edge processing chunk N-1 SHALL also set cout = final carry and ovf = carry-into-MSB XOR carry-out-of-MSB, then move to DONE.
REQ-019 DONE SHALL last exactly one cycle, then move to IDLE unconditionally.
REQ-020 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-021 Latency: with start accepted at edge k, done SHALL be high from edge k+N to edge k+N+1; busy SHALL be high from edge k to edge k+N.
REQ-022 start while in RUN or DONE SHALL be ignored; the operation in flight SHALL NOT be disturbed.
REQ-023 z, cout and ovf SHALL stay stable from done until the next accepted start; partial z during RUN is undefined for consumers.
REQ-024 Input changes on a, b or sub after acceptance SHALL NOT affect the result.
REQ-025 With N=1 (CHUNK=WIDTH), the block SHALL complete in one RUN cycle with the same timing rules.

Reset
REQ-026 rst_n=0 SHALL, asynchronously, force state=IDLE, index=0, carry=0, z=0, cout=0, ovf=0, busy=0, done=0.
REQ-027 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow.
REQ-028 The first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-029 The FSM state encoding SHALL live in a shared package y_arith_pkg, alongside the sub/add mode encoding.
REQ-030 One sub-module y_adder_chunk SHALL be used: a CHUNK-bit ripple adder built from full-adder cells, with outputs sum, carry-out and carry-into-top-bit.
REQ-031 There SHALL be exactly one y_adder_chunk instance, time-multiplexed by the chunk index.

Verification (WIDTH=8, CHUNK=4, N=2 unless stated)
REQ-032 a=8'h0F, b=8'h01, sub=0, start at edge 0 -> done high edges 2-3, z=8'h10, cout=0, ovf=0.
REQ-033 a=8'h7F, b=8'h01, sub=0 -> z=8'h80, cout=0, ovf=1; a=8'hFF, b=8'h01 -> z=8'h00, cout=1, ovf=0.
REQ-034 a=8'h00, b=8'h01, sub=1 -> z=8'hFF, cout=0, ovf=0; a=8'h80, b=8'h01, sub=1 -> z=8'h7F, cout=1, ovf=1.
REQ-035 start re-pulsed with new operands at edge 1 of an operation -> ignored, and the original result is delivered at edge 2.
REQ-036 rst_n low at edge 1 of an operation -> all outputs 0 immediately and no done pulse; the next start completes correctly.
REQ-037 WIDTH=4, CHUNK=1 exhaustive check over all a, b and sub -> {cout,z} matches a+b (or a+~b+1) and ovf matches the signed check for every case; PASS/FAIL printed per vector.
